cmd_uart_link: RTL and testbench
================================

CMD_UART_LINK -- requirements
Module: cmd_uart_link

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000, inter-byte timeout in clk cycles for a partial command.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 rx_rdy  input  1  one-cycle pulse; byte available on rx_data from UART receiver.
REQ-005 rx_data  input  8  received byte, valid when rx_rdy=1.
REQ-006 tx_done  input  1  one-cycle pulse; UART transmitter finished the current byte.
REQ-007 clr_cmd_rdy  input  1  command consumer releases the held command.
REQ-008 send_resp  input  1  one-cycle request to transmit resp_data.
REQ-009 resp_data  input  8  response byte, sampled when send_resp=1.
REQ-010 cmd  output  24  assembled command, byte1 in [23:16], byte2 in [15:8], byte3 in [7:0].
REQ-011 cmd_rdy  output  1  level; cmd is complete and stable.
REQ-012 trmt  output  1  one-cycle pulse starting UART transmission of tx_data.
REQ-013 tx_data  output  8  byte to transmit, held stable from trmt until tx_done.
REQ-014 resp_sent  output  1  one-cycle pulse; requested response fully transmitted.
REQ-015 frame_err  output  1  one-cycle pulse; partial command discarded on timeout.
REQ-016 overrun  output  1  one-cycle pulse; byte dropped while a command is held.

Function
REQ-017 RX FSM states: WAIT_B1, WAIT_B2, WAIT_B3, HOLD.
REQ-018 WAIT_B1 + rx_rdy: cmd[23:16]<=rx_data, go WAIT_B2; WAIT_B2 + rx_rdy: cmd[15:8]<=rx_data, go WAIT_B3.
REQ-019 WAIT_B3 + rx_rdy: cmd[7:0]<=rx_data, go HOLD, cmd_rdy=1 on the following cycle (1-cycle latency from third rx_rdy).
REQ-020 HOLD: cmd and cmd_rdy stable; rx_rdy without clr_cmd_rdy drops byte, pulses overrun next cycle.
REQ-021 HOLD + clr_cmd_rdy: cmd_rdy=0 next cycle, go WAIT_B1; cmd retains last value.
REQ-022 HOLD + clr_cmd_rdy + rx_rdy same cycle: clear wins, byte captured as cmd[23:16], go WAIT_B2, no overrun.
REQ-023 clr_cmd_rdy outside HOLD: ignored.
REQ-024 Timeout counter: cleared on every accepted byte and in WAIT_B1/HOLD; increments in WAIT_B2/WAIT_B3.
REQ-025 Counter reaching TIMEOUT_CYC-1 in WAIT_B2/WAIT_B3 without rx_rdy: go WAIT_B1, frame_err pulse next cycle, cmd_rdy stays 0.
REQ-026 rx_rdy on the timeout cycle: byte accepted, timeout suppressed.
REQ-027 TX FSM states: TX_IDLE, TX_BUSY.
REQ-028 TX_IDLE + send_resp: tx_data<=resp_data, trmt=1 next cycle (single cycle), go TX_BUSY.
REQ-029 TX_BUSY + tx_done: resp_sent pulse next cycle, go TX_IDLE; send_resp in TX_BUSY ignored.
REQ-030 tx_done in TX_IDLE: ignored, no resp_sent.
REQ-031 RX and TX FSMs independent; simultaneous rx_rdy/send_resp both serviced same cycle.

Reset
REQ-032 rst_n=0 at a clock edge: RX->WAIT_B1, TX->TX_IDLE, cmd=24'h000000, tx_data=8'h00, timeout counter=0.
REQ-033 During/after reset: cmd_rdy, trmt, resp_sent, frame_err, overrun all 0.
REQ-034 Reset mid-command or mid-transmit discards partial bytes/response; no resp_sent issued for aborted byte.

Structure
REQ-035 Package cmd_link_pkg holds rx_state_t, tx_state_t enums and TIMEOUT_CYC default.
REQ-036 One sub-module, inter_byte_timer (clear, enable, expire pulse), instantiated once.

Verification
REQ-037 rx bytes 8'h02,8'h00,8'h0C spaced 10 cycles -> cmd=24'h02000C, cmd_rdy=1 one cycle after third rx_rdy; clr_cmd_rdy -> cmd_rdy=0 next cycle.
REQ-038 TIMEOUT_CYC=100; bytes 8'h04,8'h01 then silence -> frame_err pulse at cycle 100 after second byte, cmd_rdy=0; then 8'h07,8'h00,8'h00 -> cmd=24'h070000.
REQ-039 In HOLD with cmd=24'h03008C, rx byte 8'h55 -> overrun pulse, cmd unchanged; clr_cmd_rdy with rx_rdy(8'h09) same cycle -> RX in WAIT_B2, cmd[23:16]=8'h09.
REQ-040 send_resp with resp_data=8'hA5 -> trmt one cycle, tx_data=8'hA5; second send_resp 8'hEE while busy ignored; tx_done -> one resp_sent, tx_data still 8'hA5.
REQ-041 rst_n=0 after two bytes and during TX_BUSY -> all outputs reset; later tx_done produces no resp_sent; next 3 bytes assemble normally.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared types and defaults for the command/response UART link.
// Holds the RX and TX state encodings and the default inter-byte timeout.
package cmd_link_pkg;

  typedef enum logic [1:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    HOLD
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'd50000;

endpackage

// File: rtl/inter_byte_timer.sv
// Counts idle cycles between command bytes.
// Expires on the cycle the count sits at LIMIT-1 while enabled and not cleared.
module inter_byte_timer #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // A clear in the same cycle means a byte arrived, so the timeout is suppressed.
  assign expire = enable && !clear && (count == LIMIT - 16'd1);

endmodule

// File: rtl/cmd_uart_link.sv
// Assembles 3-byte commands from a UART receiver and sends single response bytes.
// RX and TX sides run as independent FSMs; both expose their state for debug.
module cmd_uart_link
  import cmd_link_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        tx_done,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        resp_sent,
  output logic        frame_err,
  output logic        overrun,
  output rx_state_t   rx_state_dbg,
  output tx_state_t   tx_state_dbg
);

  // Handshake: rx_rdy, send_resp and tx_done are single-cycle strobes with no
  // back-pressure; a strobe arriving when its FSM cannot use it is dropped.

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic tmr_clear, tmr_enable, tmr_expire;
  logic load_b1, load_b2, load_b3, drop_byte, tmo_err;
  logic tx_load, tx_finish;

  assign tmr_enable = (rx_state == WAIT_B2) || (rx_state == WAIT_B3);
  assign tmr_clear  = rx_rdy || (rx_state == WAIT_B1) || (rx_state == HOLD);

  inter_byte_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= WAIT_B1;
    else        rx_state <= rx_next;
  end

  // RX next state
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      WAIT_B1: if (rx_rdy) rx_next = WAIT_B2;
      WAIT_B2: begin
        if (rx_rdy)          rx_next = WAIT_B3;
        else if (tmr_expire) rx_next = WAIT_B1;
      end
      WAIT_B3: begin
        if (rx_rdy)          rx_next = HOLD;
        else if (tmr_expire) rx_next = WAIT_B1;
      end
      HOLD: if (clr_cmd_rdy) rx_next = rx_rdy ? WAIT_B2 : WAIT_B1;
      default: rx_next = WAIT_B1;
    endcase
  end

  // RX outputs; a release and a new first byte in the same cycle restart assembly
  always_comb begin
    load_b1   = rx_rdy && ((rx_state == WAIT_B1) || ((rx_state == HOLD) && clr_cmd_rdy));
    load_b2   = rx_rdy && (rx_state == WAIT_B2);
    load_b3   = rx_rdy && (rx_state == WAIT_B3);
    drop_byte = rx_rdy && (rx_state == HOLD) && !clr_cmd_rdy;
    tmo_err   = tmr_expire;
  end

  assign cmd_rdy = (rx_state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd       <= 24'h000000;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_b1) cmd[23:16] <= rx_data;
      if (load_b2) cmd[15:8]  <= rx_data;
      if (load_b3) cmd[7:0]   <= rx_data;
      overrun   <= drop_byte;
      frame_err <= tmo_err;
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (send_resp) tx_next = TX_BUSY;
      TX_BUSY: if (tx_done)   tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX outputs
  always_comb begin
    tx_load   = (tx_state == TX_IDLE) && send_resp;
    tx_finish = (tx_state == TX_BUSY) && tx_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data   <= 8'h00;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      if (tx_load) tx_data <= resp_data;
      trmt      <= tx_load;
      resp_sent <= tx_finish;
    end
  end

  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

endmodule

// File: tb/tb_cmd_uart_link.sv
// Self-checking bench for cmd_uart_link with a 100-cycle inter-byte timeout.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cmd_uart_link;
  import cmd_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic [23:0] cmd;
  logic        cmd_rdy, trmt, resp_sent, frame_err, overrun;
  logic [7:0]  tx_data;
  rx_state_t   rx_state_dbg;
  tx_state_t   tx_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [23:0] cmd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  cmd_uart_link #(.TIMEOUT_CYC(16'd100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_rdy       (rx_rdy),
    .rx_data      (rx_data),
    .tx_done      (tx_done),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp_data    (resp_data),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .trmt         (trmt),
    .tx_data      (tx_data),
    .resp_sent    (resp_sent),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .rx_state_dbg (rx_state_dbg),
    .tx_state_dbg (tx_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: all start and end just after a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx_rdy = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send(input logic [7:0] b);
    send_resp = 1'b1;
    resp_data = b;
    @(negedge clk);
    send_resp = 1'b0;
    resp_data = 8'h00;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({cmd_rdy, trmt, resp_sent, frame_err, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 00000", {cmd_rdy, trmt, resp_sent, frame_err, overrun});
    end
    checks++;
    if (cmd !== 24'h000000 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got cmd=%h tx_data=%h want 000000/00", cmd, tx_data);
    end
    checks++;
    if (rx_state_dbg !== WAIT_B1 || tx_state_dbg !== TX_IDLE) begin
      errors++;
      $display("FAIL reset_state: got rx=%0d tx=%0d want 0/0", rx_state_dbg, tx_state_dbg);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [23:0] exp_cmd;
    cmd_exp_q.push_back(24'h02000C);
    drive_rx(8'h02);
    idle(9);
    drive_rx(8'h00);
    idle(9);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_rdy: got %b want 0", cmd_rdy);
    end
    drive_rx(8'h0C);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL basic_cmd: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    idle(4);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL basic_hold: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== exp_cmd || rx_state_dbg !== WAIT_B1) begin
      errors++;
      $display("FAIL basic_clear: got rdy=%b cmd=%h rx=%0d want 0/%h/0", cmd_rdy, cmd, rx_state_dbg, exp_cmd);
    end
  endtask

  task automatic test_timeout();
    logic [23:0] exp_cmd;
    int first_k;
    int pulses;
    logic rdy_seen;
    first_k = -1;
    pulses = 0;
    rdy_seen = 1'b0;
    drive_rx(8'h04);
    idle(2);
    drive_rx(8'h01);
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (cmd_rdy !== 1'b0) rdy_seen = 1'b1;
    end
    checks++;
    if (first_k != 100 || pulses != 1) begin
      errors++;
      $display("FAIL timeout_frame_err: got first=%0d pulses=%0d want 100/1", first_k, pulses);
    end
    checks++;
    if (rdy_seen !== 1'b0 || rx_state_dbg !== WAIT_B1) begin
      errors++;
      $display("FAIL timeout_state: got rdy_seen=%b rx=%0d want 0/0", rdy_seen, rx_state_dbg);
    end
    cmd_exp_q.push_back(24'h070000);
    drive_rx(8'h07);
    idle(3);
    drive_rx(8'h00);
    idle(3);
    drive_rx(8'h00);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL timeout_recover: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_clr();
  endtask

  task automatic test_timeout_edge();
    logic [23:0] exp_cmd;
    cmd_exp_q.push_back(24'h112233);
    drive_rx(8'h11);
    idle(99);
    drive_rx(8'h22);
    checks++;
    if (frame_err !== 1'b0 || rx_state_dbg !== WAIT_B3) begin
      errors++;
      $display("FAIL timeout_edge_accept: got ferr=%b rx=%0d want 0/2", frame_err, rx_state_dbg);
    end
    idle(5);
    drive_rx(8'h33);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL timeout_edge_cmd: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_clr();
  endtask

  task automatic test_overrun();
    logic [23:0] exp_cmd;
    cmd_exp_q.push_back(24'h03008C);
    drive_rx(8'h03);
    drive_rx(8'h00);
    drive_rx(8'h8C);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL overrun_setup: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    idle(2);
    drive_rx(8'h55);
    checks++;
    if (overrun !== 1'b1 || cmd !== exp_cmd || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got ovr=%b cmd=%h rdy=%b want 1/%h/1", overrun, cmd, cmd_rdy, exp_cmd);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_single: got %b want 0", overrun);
    end
    clr_cmd_rdy = 1'b1;
    rx_rdy = 1'b1;
    rx_data = 8'h09;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    checks++;
    if (rx_state_dbg !== WAIT_B2 || cmd[23:16] !== 8'h09 || overrun !== 1'b0 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear_win: got rx=%0d b1=%h ovr=%b rdy=%b want 1/09/0/0",
               rx_state_dbg, cmd[23:16], overrun, cmd_rdy);
    end
    pulse_clr();
    checks++;
    if (rx_state_dbg !== WAIT_B2) begin
      errors++;
      $display("FAIL clr_ignored: got rx=%0d want 1", rx_state_dbg);
    end
    cmd_exp_q.push_back(24'h090A0B);
    drive_rx(8'h0A);
    drive_rx(8'h0B);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL overrun_followup: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_clr();
  endtask

  task automatic test_tx();
    logic [7:0] exp_tx;
    tx_exp_q.push_back(8'hA5);
    pulse_send(8'hA5);
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL tx_start: got trmt=%b data=%h want 1/a5", trmt, tx_data);
    end
    @(negedge clk);
    checks++;
    if (trmt !== 1'b0) begin
      errors++;
      $display("FAIL tx_trmt_single: got %b want 0", trmt);
    end
    pulse_send(8'hEE);
    checks++;
    if (trmt !== 1'b0 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL tx_busy_ignore: got trmt=%b data=%h want 0/a5", trmt, tx_data);
    end
    idle(3);
    pulse_done();
    exp_tx = tx_exp_q.pop_front();
    checks++;
    if (resp_sent !== 1'b1 || tx_data !== exp_tx || tx_state_dbg !== TX_IDLE) begin
      errors++;
      $display("FAIL tx_done: got sent=%b data=%h tx=%0d want 1/%h/0", resp_sent, tx_data, tx_state_dbg, exp_tx);
    end
    @(negedge clk);
    checks++;
    if (resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL tx_sent_single: got %b want 0", resp_sent);
    end
    pulse_done();
    checks++;
    if (resp_sent !== 1'b0 || trmt !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_done: got sent=%b trmt=%b want 0/0", resp_sent, trmt);
    end
  endtask

  task automatic test_simultaneous();
    logic [23:0] exp_cmd;
    logic [7:0]  exp_tx;
    cmd_exp_q.push_back(24'h414243);
    tx_exp_q.push_back(8'h5A);
    rx_rdy = 1'b1;
    rx_data = 8'h41;
    send_resp = 1'b1;
    resp_data = 8'h5A;
    @(negedge clk);
    rx_rdy = 1'b0;
    send_resp = 1'b0;
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'h5A || rx_state_dbg !== WAIT_B2) begin
      errors++;
      $display("FAIL simul_both: got trmt=%b data=%h rx=%0d want 1/5a/1", trmt, tx_data, rx_state_dbg);
    end
    drive_rx(8'h42);
    drive_rx(8'h43);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL simul_cmd: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_done();
    exp_tx = tx_exp_q.pop_front();
    checks++;
    if (resp_sent !== 1'b1 || tx_data !== exp_tx) begin
      errors++;
      $display("FAIL simul_tx: got sent=%b data=%h want 1/%h", resp_sent, tx_data, exp_tx);
    end
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp_cmd;
    drive_rx(8'h61);
    drive_rx(8'h62);
    pulse_send(8'h77);
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (cmd !== 24'h000000 || tx_data !== 8'h00 ||
        {cmd_rdy, trmt, resp_sent, frame_err, overrun} !== 5'b0 ||
        rx_state_dbg !== WAIT_B1 || tx_state_dbg !== TX_IDLE) begin
      errors++;
      $display("FAIL reset_mid: got cmd=%h data=%h pulses=%b rx=%0d tx=%0d want 000000/00/00000/0/0",
               cmd, tx_data, {cmd_rdy, trmt, resp_sent, frame_err, overrun}, rx_state_dbg, tx_state_dbg);
    end
    rst_n = 1'b1;
    idle(2);
    pulse_done();
    checks++;
    if (resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_sent: got %b want 0", resp_sent);
    end
    cmd_exp_q.push_back(24'h0D0E0F);
    drive_rx(8'h0D);
    idle(2);
    drive_rx(8'h0E);
    idle(2);
    drive_rx(8'h0F);
    exp_cmd = cmd_exp_q.pop_front();
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
      errors++;
      $display("FAIL reset_reassemble: got rdy=%b cmd=%h want 1/%h", cmd_rdy, cmd, exp_cmd);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b1, b2, b3;
    logic [23:0] exp_cmd;
    for (int n = 0; n < 8; n++) begin
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      b3 = 8'($urandom_range(0, 255));
      cmd_exp_q.push_back({b1, b2, b3});
      drive_rx(b1);
      idle($urandom_range(0, 20));
      drive_rx(b2);
      idle($urandom_range(0, 20));
      drive_rx(b3);
      exp_cmd = cmd_exp_q.pop_front();
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
        errors++;
        $display("FAIL b2b_cmd[%0d]: got rdy=%b cmd=%h want 1/%h", n, cmd_rdy, cmd, exp_cmd);
      end
      pulse_clr();
    end
    checks++;
    if (cmd_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d/%0d want 0/0", cmd_exp_q.size(), tx_exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_edge();
    test_overrun();
    test_tx();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
